upsizer_padder: RTL and testbench



---
 rtl/upsizer_padder_if.sv | 38 +++
 rtl/upsizer_padder.sv | 182 ++++++++++++++++++
 tb/tb_upsizer_padder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/upsizer_padder_if.sv
`default_nettype none
// ============================================================================
// Module      : upsizer_padder_if
// Description : Handshake and pixel bus bundle for upsizer_padder.
//               Carries the frame start / end strobes, the 8-bit RGB source
//               stream with its valid/ready pair, and the packed output pixel
//               stream with its valid/ready pair.
//               master : side that starts frames, sources RGB pixels and
//                        sinks output pixels (display-path controller).
//               slave  : the upsizer/padder itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface upsizer_padder_if #(
    parameter int DATA_WIDTH = 24
);
    logic                  startNewImage;
    logic [7:0]            inRed;
    logic [7:0]            inGreen;
    logic [7:0]            inBlue;
    logic                  inPixelValid;
    logic                  inReady;
    logic [DATA_WIDTH-1:0] outPixelData;
    logic                  outPixelValid;
    logic                  outReady;
    logic                  endOfImage;
    logic                  busy;

    modport master (
        output startNewImage, inRed, inGreen, inBlue, inPixelValid, outReady,
        input  inReady, outPixelData, outPixelValid, endOfImage, busy
    );

    modport slave (
        input  startNewImage, inRed, inGreen, inBlue, inPixelValid, outReady,
        output inReady, outPixelData, outPixelValid, endOfImage, busy
    );
endinterface
`default_nettype wire

// File: rtl/upsizer_padder.sv
`default_nettype none
// ============================================================================
// Module      : upsizer_padder
// Description : Expands an IN_DIM x IN_DIM RGB image to an OUTPUT_WIDTH x
//               OUTPUT_HEIGHT raster. Every source pixel is replicated 2x2
//               and the image is centred in a PAD_COLOR border
//               (VERT_PAD_COUNT rows top/bottom, HORIZ_PAD_COUNT columns
//               left/right). Source rows are captured into a one-line buffer
//               on the even output row and replayed on the odd row.
// Ports       : clock  - system clock (rising edge)
//               reset  - synchronous, active-high reset
//               bus    - upsizer_padder_if.slave: startNewImage, RGB input
//                        stream (inPixelValid/inReady), packed {B,G,R}
//                        output stream (outPixelValid/outReady), endOfImage
//                        pulse and busy status.
// Revision    : 1.0 - initial release
// ============================================================================
module upsizer_padder #(
    parameter int                    DATA_WIDTH      = 24,
    parameter int                    OUTPUT_WIDTH    = 640,
    parameter int                    OUTPUT_HEIGHT   = 480,
    parameter int                    VERT_PAD_COUNT  = 16,
    parameter int                    HORIZ_PAD_COUNT = 96,
    parameter int                    IN_DIM          = 224,
    parameter logic [DATA_WIDTH-1:0] PAD_COLOR       = '0
) (
    input  wire logic         clock,
    input  wire logic         reset,
    upsizer_padder_if.slave   bus
);

    localparam int          c_IDX_W    = $clog2(IN_DIM);
    localparam logic [10:0] c_LAST_COL = 11'(OUTPUT_WIDTH - 1);
    localparam logic [10:0] c_LAST_ROW = 11'(OUTPUT_HEIGHT - 1);
    localparam logic [10:0] c_COL_LO   = 11'(HORIZ_PAD_COUNT);
    localparam logic [10:0] c_COL_HI   = 11'(OUTPUT_WIDTH - HORIZ_PAD_COUNT);
    localparam logic [10:0] c_ROW_LO   = 11'(VERT_PAD_COUNT);
    localparam logic [10:0] c_ROW_HI   = 11'(OUTPUT_HEIGHT - VERT_PAD_COUNT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_nextState;

    logic [10:0]           r_rowCounter;
    logic [10:0]           r_colCounter;
    logic [DATA_WIDTH-1:0] r_outPixelData;
    logic                  r_outPixelValid;
    logic                  r_lastIssued;     // final raster pixel already generated
    logic [DATA_WIDTH-1:0] r_lineBuf [IN_DIM];

    logic                  w_advance;
    logic                  w_inWindow;
    logic                  w_replayRow;
    logic                  w_oddCol;
    logic                  w_needPixel;
    logic [c_IDX_W-1:0]    w_idx;
    logic [DATA_WIDTH-1:0] w_srcPixel;
    logic [DATA_WIDTH-1:0] w_genPixel;
    logic                  w_lastPos;
    logic                  w_start;
    logic                  w_generate;
    logic                  w_inReady;
    logic                  w_busy;
    logic                  w_endOfImage;

    // Output register may take a new pixel when empty or being drained.
    assign w_advance   = !r_outPixelValid || bus.outReady;

    assign w_inWindow  = (r_rowCounter >= c_ROW_LO) && (r_rowCounter < c_ROW_HI) &&
                         (r_colCounter >= c_COL_LO) && (r_colCounter < c_COL_HI);

    // Parity of the window-relative offsets, taken without a full subtract.
    assign w_replayRow = r_rowCounter[0] ^ c_ROW_LO[0];
    assign w_oddCol    = r_colCounter[0] ^ c_COL_LO[0];
    assign w_needPixel = w_inWindow && !w_replayRow && !w_oddCol;

    assign w_idx       = c_IDX_W'((r_colCounter - c_COL_LO) >> 1);
    assign w_srcPixel  = DATA_WIDTH'({bus.inBlue, bus.inGreen, bus.inRed});
    assign w_genPixel  = !w_inWindow ? PAD_COLOR :
                         w_needPixel ? w_srcPixel : r_lineBuf[w_idx];
    assign w_lastPos   = (r_rowCounter == c_LAST_ROW) && (r_colCounter == c_LAST_COL);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState  = r_state;
        w_start      = 1'b0;
        w_generate   = 1'b0;
        w_inReady    = 1'b0;
        w_busy       = 1'b0;
        w_endOfImage = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.startNewImage) begin
                    w_start     = 1'b1;
                    w_nextState = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (!r_lastIssued) begin
                    w_inReady  = w_advance && w_needPixel;
                    // A position that needs a source pixel stalls until one is offered.
                    w_generate = w_advance && (!w_needPixel || bus.inPixelValid);
                end else if (r_outPixelValid && bus.outReady) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                w_busy       = 1'b1;
                w_endOfImage = 1'b1;
                w_nextState  = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Raster counters and output register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rowCounter    <= '0;
            r_colCounter    <= '0;
            r_outPixelData  <= '0;
            r_outPixelValid <= 1'b0;
            r_lastIssued    <= 1'b0;
        end else if (w_start) begin
            r_rowCounter    <= '0;
            r_colCounter    <= '0;
            r_outPixelValid <= 1'b0;
            r_lastIssued    <= 1'b0;
        end else if ((r_state == S_RUN) && w_advance) begin
            if (w_generate) begin
                r_outPixelData  <= w_genPixel;
                r_outPixelValid <= 1'b1;
                if (w_lastPos) begin
                    r_lastIssued <= 1'b1;
                end
                if (r_colCounter == c_LAST_COL) begin
                    r_colCounter <= '0;
                    r_rowCounter <= r_rowCounter + 11'd1;
                end else begin
                    r_colCounter <= r_colCounter + 11'd1;
                end
            end else begin
                r_outPixelValid <= 1'b0;
            end
        end
    end

    // Line buffer: contents are don't-care after reset, so it is not reset.
    always_ff @(posedge clock) begin
        if (w_generate && w_needPixel) begin
            r_lineBuf[w_idx] <= w_srcPixel;
        end
    end

    assign bus.inReady       = w_inReady;
    assign bus.outPixelData  = r_outPixelData;
    assign bus.outPixelValid = r_outPixelValid;
    assign bus.endOfImage    = w_endOfImage;
    assign bus.busy          = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_upsizer_padder.sv
`default_nettype none
// ============================================================================
// Module      : tb_upsizer_padder
// Description : Self-checking bench for upsizer_padder on a reduced geometry
//               (8x8 source, 28x22 raster). Output pixels are compared with a
//               reference computed directly from the source image by
//               coordinate arithmetic; handshake counts, hold stability,
//               reset behaviour and start-ignore cases are also checked.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_upsizer_padder;

    localparam int          IN    = 8;
    localparam int          HP    = 6;
    localparam int          VP    = 3;
    localparam int          W     = 2*IN + 2*HP;
    localparam int          H     = 2*IN + 2*VP;
    localparam int          PIX   = W*H;
    localparam int          NSRC  = IN*IN;
    localparam logic [23:0] PAD   = 24'h000000;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    upsizer_padder_if #(.DATA_WIDTH(24)) bus ();

    upsizer_padder #(
        .DATA_WIDTH     (24),
        .OUTPUT_WIDTH   (W),
        .OUTPUT_HEIGHT  (H),
        .VERT_PAD_COUNT (VP),
        .HORIZ_PAD_COUNT(HP),
        .IN_DIM         (IN),
        .PAD_COLOR      (PAD)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int          checkCount = 0;
    int          errorCount = 0;
    logic [23:0] src    [NSRC];
    logic [23:0] outCap [PIX];
    logic [23:0] cap1   [PIX];

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: raster position -> border colour or 2x2-replicated source pixel.
    function automatic logic [23:0] ref_pixel(input int n);
        int r;
        int c;
        r = n / W;
        c = n % W;
        if (r < VP || r >= H - VP || c < HP || c >= W - HP) return PAD;
        return src[((r - VP) / 2) * IN + (c - HP) / 2];
    endfunction

    task automatic run_frame(input int readyPct, input int validPct, input bit rcPattern,
                             input int stallK, input int midStartCyc);
        int          outIdx;
        int          inIdx;
        int          eoiSeen;
        int          cyc;
        int          stallLeft;
        bit          hold;
        logic [23:0] heldData;
        for (int k = 0; k < NSRC; k++) begin
            src[k] = rcPattern ? {8'h00, 8'(k / IN), 8'(k % IN)} : 24'($urandom);
        end
        outIdx = 0; inIdx = 0; eoiSeen = 0; cyc = 0; stallLeft = 10;
        hold = 1'b0; heldData = '0;
        while (eoiSeen == 0 && cyc < 20000) begin
            @(negedge clock);
            bus.startNewImage = (cyc == 0) || (cyc == midStartCyc);
            bus.outReady      = ($urandom_range(99) < readyPct);
            if (inIdx == stallK && stallLeft > 0) begin
                bus.inPixelValid = 1'b0;
                stallLeft--;
            end else begin
                bus.inPixelValid = ($urandom_range(99) < validPct);
            end
            if (bus.inPixelValid && inIdx < NSRC)
                {bus.inBlue, bus.inGreen, bus.inRed} = src[inIdx];
            else
                {bus.inBlue, bus.inGreen, bus.inRed} = 24'($urandom);
            #1;
            if (cyc > 0) check_value("busy_run", bus.busy, 1);
            if (hold) begin
                check_value("hold_valid", bus.outPixelValid, 1);
                check_value("hold_data", bus.outPixelData, heldData);
            end
            if (bus.inPixelValid && bus.inReady) inIdx++;
            if (bus.outPixelValid && bus.outReady) begin
                if (outIdx < PIX) begin
                    outCap[outIdx] = bus.outPixelData;
                    check_value($sformatf("pix%0d", outIdx), bus.outPixelData, ref_pixel(outIdx));
                end
                outIdx++;
            end
            hold     = bus.outPixelValid && !bus.outReady;
            heldData = bus.outPixelData;
            if (bus.endOfImage) eoiSeen = 1;
            cyc++;
        end
        check_value("out_count", outIdx, PIX);
        check_value("in_count", inIdx, NSRC);
        check_value("eoi_seen", eoiSeen, 1);
        // Start coinciding with endOfImage must be ignored.
        bus.startNewImage = 1'b1;
        bus.inPixelValid  = 1'b1;
        bus.outReady      = 1'b1;
        @(negedge clock);
        bus.startNewImage = 1'b0;
        #1;
        check_value("eoi_one_cycle", bus.endOfImage, 0);
        check_value("busy_after_done", bus.busy, 0);
        @(negedge clock);
        #1;
        check_value("start_at_eoi_ignored", bus.busy, 0);
        check_value("idle_inready", bus.inReady, 0);
    endtask

    initial begin
        reset = 1'b1;
        bus.startNewImage = 1'b0;
        bus.inPixelValid  = 1'b0;
        bus.outReady      = 1'b0;
        {bus.inBlue, bus.inGreen, bus.inRed} = '0;
        repeat (3) @(negedge clock);
        #1;
        check_value("rst_valid", bus.outPixelValid, 0);
        check_value("rst_data", bus.outPixelData, 0);
        check_value("rst_inready", bus.inReady, 0);
        check_value("rst_busy", bus.busy, 0);
        check_value("rst_eoi", bus.endOfImage, 0);
        reset = 1'b0;

        // Full frame, row/column pattern, no stalls.
        run_frame(100, 100, 1'b1, -1, -1);
        check_value("pt_win_origin", outCap[VP*W + HP], 24'h000000);
        check_value("pt_win_col1", outCap[VP*W + HP + 1], 24'h000000);
        check_value("pt_win_row1", outCap[(VP+1)*W + HP], 24'h000000);
        check_value("pt_src_1_2", outCap[(VP+2)*W + HP + 4], 24'h000102);
        check_value("pt_replay_0_2", outCap[(VP+1)*W + HP + 5], 24'h000002);
        check_value("pt_last", outCap[PIX-1], PAD);
        check_value("pt_first", outCap[0], PAD);
        check_value("pt_top_border", outCap[(VP-1)*W + W/2], PAD);
        for (int i = 0; i < PIX; i++) cap1[i] = outCap[i];

        // Same image under random backpressure: identical sequence.
        run_frame(50, 100, 1'b1, -1, -1);
        begin
            int diffs;
            diffs = 0;
            for (int i = 0; i < PIX; i++) if (outCap[i] !== cap1[i]) diffs++;
            check_value("bp_same_sequence", diffs, 0);
        end

        // Input starvation for 10 cycles at source (2,2).
        run_frame(100, 100, 1'b1, 2*IN + 2, -1);

        // Reset mid-frame.
        @(negedge clock);
        bus.startNewImage = 1'b1;
        bus.outReady      = 1'b1;
        bus.inPixelValid  = 1'b1;
        @(negedge clock);
        bus.startNewImage = 1'b0;
        repeat (100) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        #1;
        check_value("midrst_valid", bus.outPixelValid, 0);
        check_value("midrst_inready", bus.inReady, 0);
        check_value("midrst_busy", bus.busy, 0);
        check_value("midrst_eoi", bus.endOfImage, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        #1;
        check_value("post_rst_idle_inready", bus.inReady, 0);
        check_value("post_rst_idle_busy", bus.busy, 0);

        // Random data, random valid/ready, ignored mid-frame start.
        run_frame(60, 70, 1'b0, -1, 40);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
`default_nettype wire
